// File: rtl/comp32_bist.sv
// comp32_bist: on-chip stimulus generator and response checker for the comp32 A>B comparator.
// Issues directed corner vectors, then LFSR vectors, and checks z against a delayed golden a>b.
module comp32_bist #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_VECTORS = 256,
  parameter int               DUT_LAT     = 1,
  parameter logic [WIDTH-1:0] SEED_A      = WIDTH'(32'hACE12468),
  parameter logic [WIDTH-1:0] SEED_B      = WIDTH'(32'h1357BDF9)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count
);

  localparam logic [WIDTH-1:0] LFSR_MASK  = WIDTH'(32'h80200003);
  localparam logic [15:0]      LAST_IDX   = 16'(NUM_VECTORS);
  localparam logic [15:0]      DRAIN_LAST = 16'(DUT_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_lfsrA;
  logic [WIDTH-1:0]   r_lfsrB;
  logic [15:0]        r_idx;
  logic [15:0]        r_drainCnt;
  logic [15:0]        r_errCount;
  logic [15:0]        r_vecCount;
  logic [DUT_LAT-1:0] r_expPipe;
  logic [DUT_LAT-1:0] r_vldPipe;
  logic               r_busy;
  logic               r_done;

  logic               w_restart;
  logic               w_cmpValid;
  logic               w_mismatch;
  logic [WIDTH-1:0]   w_nextA;
  logic [WIDTH-1:0]   w_nextB;

  function automatic logic [WIDTH-1:0] galoisStep(input logic [WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
  endfunction

  assign w_restart  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_cmpValid = r_vldPipe[DUT_LAT-1];
  assign w_mismatch = w_cmpValid && (z != r_expPipe[DUT_LAT-1]);

  // Vector 0 is loaded by the restart itself; r_idx here is always the next index to present.
  always_comb begin
    w_nextA = r_lfsrA;
    w_nextB = r_lfsrB;
    case (r_idx)
      16'd1: begin
        w_nextA = '1;
        w_nextB = '0;
      end
      16'd2: begin
        w_nextA = '0;
        w_nextB = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_lfsrA    <= SEED_A;
      r_lfsrB    <= SEED_B;
      r_idx      <= '0;
      r_drainCnt <= '0;
      r_errCount <= '0;
      r_vecCount <= '0;
      r_expPipe  <= '0;
      r_vldPipe  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Golden a>b from the registered operands; valid only for vectors issued in RUN.
      r_expPipe[0] <= (r_a > r_b);
      r_vldPipe[0] <= (r_state == RUN);
      for (int k = 1; k < DUT_LAT; k++) begin
        r_expPipe[k] <= r_expPipe[k-1];
        r_vldPipe[k] <= r_vldPipe[k-1];
      end

      if (w_restart) begin
        r_errCount <= '0;
        r_vecCount <= '0;
      end else if (w_cmpValid) begin
        r_vecCount <= r_vecCount + 16'd1;
        if (w_mismatch && (r_errCount != 16'hFFFF))
          r_errCount <= r_errCount + 16'd1;
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_a     <= '0;
            r_b     <= '0;
            r_lfsrA <= SEED_A;
            r_lfsrB <= SEED_B;
            r_idx   <= 16'd1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (r_idx == LAST_IDX) begin
            r_state    <= DRAIN;
            r_drainCnt <= '0;
          end else begin
            r_a   <= w_nextA;
            r_b   <= w_nextB;
            r_idx <= r_idx + 16'd1;
            if (r_idx >= 16'd3) begin
              r_lfsrA <= galoisStep(r_lfsrA);
              r_lfsrB <= galoisStep(r_lfsrB);
            end
          end
        end
        DRAIN: begin
          if (r_drainCnt == DRAIN_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drainCnt <= r_drainCnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = (r_state == DONE) && (r_errCount == 16'd0);
  assign err_count = r_errCount;
  assign vec_count = r_vecCount;

endmodule

// File: tb/tb_comp32_bist.sv
// Scoreboard bench for comp32_bist: a behavioural comp32 (good / stuck-at-0 / inverted) sits beside
// the BIST; expected vectors and run results are queued at start and popped by monitors.
`timescale 1ns/1ps
module tb_comp32_bist;

  localparam int          N1 = 16;
  localparam int          L1 = 1;
  localparam int          N2 = 20;
  localparam int          L2 = 2;
  localparam logic [31:0] SA = 32'hACE12468;
  localparam logic [31:0] SB = 32'h1357BDF9;

  typedef struct {
    logic [15:0] err;
    logic [15:0] vec;
    logic        pass;
    int          busyLen;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [31:0] a1, b1, a2, b2;
  logic        z1, z2;
  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] err1, vec1, err2, vec2;
  logic        zReg1;
  logic [1:0]  zReg2;
  int          mode;
  int          vectors = 0;
  int          miscompares = 0;

  logic [63:0] vecQ1[$];
  logic [63:0] vecQ2[$];
  res_t        resQ1[$];
  res_t        resQ2[$];

  always #5 clk = ~clk;

  comp32_bist #(.WIDTH(32), .NUM_VECTORS(N1), .DUT_LAT(L1), .SEED_A(SA), .SEED_B(SB)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1));

  comp32_bist #(.WIDTH(32), .NUM_VECTORS(N2), .DUT_LAT(L2), .SEED_A(SA), .SEED_B(SB)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .z(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_count(vec2));

  // Behavioural comp32: registered comparator; mode 0 good, 1 stuck-at-0, 2 inverted.
  always @(posedge clk) zReg1 <= (a1 > b1);
  assign z1 = (mode == 1) ? 1'b0 : (mode == 2) ? ~zReg1 : zReg1;
  always @(posedge clk) zReg2 <= {zReg2[0], (a2 > b2)};
  assign z2 = zReg2[1];

  function automatic logic [31:0] galois(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic void genVec(input int i, output logic [31:0] va, output logic [31:0] vb);
    if (i == 0) begin va = 32'h0; vb = 32'h0; end
    else if (i == 1) begin va = 32'hFFFFFFFF; vb = 32'h0; end
    else if (i == 2) begin va = 32'h0; vb = 32'hFFFFFFFF; end
    else begin
      va = SA;
      vb = SB;
      for (int k = 0; k < i - 3; k++) begin
        va = galois(va);
        vb = galois(vb);
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic missing(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got nothing expected a queued item", name);
  endtask

  // Monitor for dut1: pops one vector per RUN cycle, one result record when done rises.
  int bc1 = 0;
  bit seen1 = 0;
  always @(negedge clk) begin
    if (rst) begin
      bc1 = 0;
      seen1 = 0;
    end else if (busy1) begin
      if (bc1 < N1) begin
        if (vecQ1.size() == 0) missing("vec1Queue");
        else checkOutput($sformatf("vec1[%0d]", bc1), {a1, b1}, vecQ1.pop_front());
      end
      bc1++;
    end else if (done1 && !seen1) begin
      res_t r;
      seen1 = 1;
      if (resQ1.size() == 0) missing("res1Queue");
      else begin
        r = resQ1.pop_front();
        checkOutput("err1", 64'(err1), 64'(r.err));
        checkOutput("vec1Count", 64'(vec1), 64'(r.vec));
        checkOutput("pass1", 64'(pass1), 64'(r.pass));
        checkOutput("busy1Len", 64'(bc1), 64'(r.busyLen));
      end
      bc1 = 0;
    end
    if (!done1) seen1 = 0;
  end

  // Monitor for dut2 (two-cycle comparator latency).
  int bc2 = 0;
  bit seen2 = 0;
  always @(negedge clk) begin
    if (rst) begin
      bc2 = 0;
      seen2 = 0;
    end else if (busy2) begin
      if (bc2 < N2) begin
        if (vecQ2.size() == 0) missing("vec2Queue");
        else checkOutput($sformatf("vec2[%0d]", bc2), {a2, b2}, vecQ2.pop_front());
      end
      bc2++;
    end else if (done2 && !seen2) begin
      res_t r;
      seen2 = 1;
      if (resQ2.size() == 0) missing("res2Queue");
      else begin
        r = resQ2.pop_front();
        checkOutput("err2", 64'(err2), 64'(r.err));
        checkOutput("vec2Count", 64'(vec2), 64'(r.vec));
        checkOutput("pass2", 64'(pass2), 64'(r.pass));
        checkOutput("busy2Len", 64'(bc2), 64'(r.busyLen));
      end
      bc2 = 0;
    end
    if (!done2) seen2 = 0;
  end

  task automatic pushRun1(input int m);
    logic [31:0] va, vb;
    int expErr;
    res_t r;
    expErr = 0;
    for (int i = 0; i < N1; i++) begin
      genVec(i, va, vb);
      vecQ1.push_back({va, vb});
      if ((m == 1) && (va > vb)) expErr++;
      if (m == 2) expErr++;
    end
    r.err = 16'(expErr);
    r.vec = 16'(N1);
    r.pass = (expErr == 0);
    r.busyLen = N1 + L1;
    resQ1.push_back(r);
  endtask

  task automatic waitDone1();
    int t;
    t = 0;
    while (!done1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("done1Reached", 64'(done1), 64'd1);
    if (!done1) begin
      vecQ1.delete();
      resQ1.delete();
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // One run of dut1: start held for 'hold' edges (all inside RUN), then wait for DONE.
  task automatic applyStimulus(input int m, input int hold);
    mode = m;
    pushRun1(m);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("startBusy", 64'(busy1), 64'd1);
    checkOutput("startDoneLow", 64'(done1), 64'd0);
    checkOutput("startPassLow", 64'(pass1), 64'd0);
    checkOutput("startErrClr", 64'(err1), 64'd0);
    checkOutput("startVecClr", 64'(vec1), 64'd0);
    repeat (hold - 1) @(posedge clk);
    #1 start1 = 1'b0;
    waitDone1();
  endtask

  task automatic checkReset1(input string tag);
    checkOutput({tag, "A"}, 64'(a1), 64'd0);
    checkOutput({tag, "B"}, 64'(b1), 64'd0);
    checkOutput({tag, "Busy"}, 64'(busy1), 64'd0);
    checkOutput({tag, "Done"}, 64'(done1), 64'd0);
    checkOutput({tag, "Pass"}, 64'(pass1), 64'd0);
    checkOutput({tag, "Err"}, 64'(err1), 64'd0);
    checkOutput({tag, "Vec"}, 64'(vec1), 64'd0);
  endtask

  task automatic runLat2();
    logic [31:0] va, vb;
    res_t r;
    int t;
    for (int i = 0; i < N2; i++) begin
      genVec(i, va, vb);
      vecQ2.push_back({va, vb});
    end
    r.err = 16'd0;
    r.vec = 16'(N2);
    r.pass = 1'b1;
    r.busyLen = N2 + L2;
    resQ2.push_back(r);
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    t = 0;
    while (!done2 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("done2Reached", 64'(done2), 64'd1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    checkReset1("rstHeld");
    rst = 1'b0;
    @(posedge clk); #1;
    checkReset1("rstIdle");

    runLat2();

    applyStimulus(0, 1);
    applyStimulus(1, $urandom_range(1, N1));
    applyStimulus(2, N1);
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus($urandom_range(0, 2), $urandom_range(1, N1));
    end

    // Reset while vector 5 is on a/b; outputs must clear before any further edge.
    mode = 0;
    pushRun1(0);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkReset1("rstMid");
    vecQ1.delete();
    resQ1.delete();
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(0, $urandom_range(1, N1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
